sbox_key_ctrl: RTL and testbench

Sequencer and arbiter for the LFSR-generated S-box/round-key table. It runs the 8-bit LFSR once per start command, filling a 256-byte table at one byte per cycle. It then serves 128-bit round-key reads to two requesters (encrypt and decrypt round datapaths) through a round-robin arbiter, and sits between the key-table generation logic and the AES round cores.

---
 rtl/ksched_pkg.sv | 18 +
 rtl/sbox_lfsr8.sv | 27 ++
 rtl/sbox_key_ctrl.sv | 144 ++++++++++++++
 tb/tb_sbox_key_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ksched_pkg.sv
// Shared types, sizes and the LFSR step for the S-box/round-key table sequencer.
package ksched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GEN,
      READY
   } state_t;

   localparam int unsigned NUM_KEYS = 16;
   localparam int unsigned KEY_W    = 128;
   localparam logic [7:0]  DEF_SEED = 8'h1D;

   function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
      return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
   endfunction

endpackage

// File: rtl/sbox_lfsr8.sv
// 8-bit LFSR byte source: loads the seed on command, steps once per enabled cycle.
module sbox_lfsr8
   import ksched_pkg::*;
(
   input  logic       clk,
   input  logic       rst_an,
   input  logic       load,
   input  logic       step,
   input  logic [7:0] seed,
   output logic [7:0] value,
   output logic       seed_zero
);

   // An all-zero seed locks the LFSR at zero, so the controller refuses it.
   assign seed_zero = (seed == '0);

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         value <= '0;
      end else if (load) begin
         value <= seed;
      end else if (step) begin
         value <= lfsr8_next(value);
      end
   end

endmodule

// File: rtl/sbox_key_ctrl.sv
// Table-fill sequencer and two-port round-robin round-key reader.
// Optional byte lookup port enabled by defining SBOX_LOOKUP_EN.
module sbox_key_ctrl
   import ksched_pkg::*;
(
   input  logic             clk,
   input  logic             rst_an,
   input  logic             start,
   input  logic             use_seed,
   input  logic [7:0]       seed,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic             req0,
   input  logic             req1,
   input  logic [3:0]       idx0,
   input  logic [3:0]       idx1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             key_vld,
   output logic [KEY_W-1:0] key_out,
   output logic             key_src,
   output logic [3:0]       key_idx
`ifdef SBOX_LOOKUP_EN
   ,
   input  logic             sb_rd,
   input  logic [7:0]       sb_addr,
   output logic [7:0]       sb_data
`endif
);

   state_t           state;
   logic [7:0]       cnt;
   logic             last_gnt;
   logic [7:0]       eff_seed;
   logic [7:0]       lfsr_val;
   logic             seed_zero;
   logic             start_ok;
   logic             xfer;
   logic [3:0]       sel_idx;
   // Row k holds key k; byte n[3:0]==0 of a row sits in the top byte lane.
   logic [15:0][7:0] tbl [NUM_KEYS];

   assign eff_seed = use_seed ? seed : DEF_SEED;
   assign start_ok = start && (state != GEN) && !seed_zero;
   assign busy     = (state == GEN);

   sbox_lfsr8 u_lfsr (
      .clk      (clk),
      .rst_an   (rst_an),
      .load     (start_ok),
      .step     (state == GEN),
      .seed     (eff_seed),
      .value    (lfsr_val),
      .seed_zero(seed_zero)
   );

   // last_gnt==1 means requester 1 was served most recently, so req0 wins a tie.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == READY && !start_ok) begin
         if (req0 && req1) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign xfer    = gnt0 | gnt1;
   assign sel_idx = gnt1 ? idx1 : idx0;

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         state    <= IDLE;
         cnt      <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         last_gnt <= 1'b1;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            GEN: begin
               cnt <= cnt + 8'd1;
               if (cnt == 8'hFF) begin
                  state <= READY;
                  done  <= 1'b1;
               end
            end
            default: begin
               if (start) begin
                  if (seed_zero) begin
                     err <= 1'b1;
                  end else begin
                     state <= GEN;
                     cnt   <= '0;
                  end
               end
            end
         endcase
         if (xfer) begin
            last_gnt <= gnt1;
         end
      end
   end

   // Table storage is deliberately unreset; READY alone marks it valid.
   always_ff @(posedge clk) begin
      if (state == GEN) begin
         tbl[cnt[7:4]][~cnt[3:0]] <= lfsr_val;
      end
   end

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         key_vld <= 1'b0;
         key_out <= '0;
         key_src <= 1'b0;
         key_idx <= '0;
      end else begin
         key_vld <= xfer;
         if (xfer) begin
            key_out <= tbl[sel_idx];
            key_src <= gnt1;
            key_idx <= sel_idx;
         end
      end
   end

`ifdef SBOX_LOOKUP_EN
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         sb_data <= '0;
      end else if (state == READY && sb_rd) begin
         sb_data <= tbl[sb_addr[7:4]][~sb_addr[3:0]];
      end
   end
`endif

endmodule

// File: tb/tb_sbox_key_ctrl.sv
// Self-checking bench for sbox_key_ctrl: vector table for arbitration, scoreboard for key reads.
module tb_sbox_key_ctrl;

   logic         clk = 1'b0;
   logic         rst_an = 1'b0;
   logic         start = 1'b0;
   logic         use_seed = 1'b0;
   logic [7:0]   seed = 8'h00;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [3:0]   idx0 = 4'd0;
   logic [3:0]   idx1 = 4'd0;
   logic         busy, done, err, gnt0, gnt1, key_vld, key_src;
   logic [127:0] key_out;
   logic [3:0]   key_idx;

   always #5 clk = ~clk;

   sbox_key_ctrl dut (
      .clk     (clk),
      .rst_an  (rst_an),
      .start   (start),
      .use_seed(use_seed),
      .seed    (seed),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .req0    (req0),
      .req1    (req1),
      .idx0    (idx0),
      .idx1    (idx1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .key_vld (key_vld),
      .key_out (key_out),
      .key_src (key_src),
      .key_idx (key_idx)
   );

   typedef struct {
      logic [127:0] key;
      logic         src;
      logic [3:0]   idx;
   } exp_t;

   typedef struct {
      logic       r0;
      logic       r1;
      logic [3:0] i0;
      logic [3:0] i1;
      logic       g0;
      logic       g1;
   } rd_vec_t;

   exp_t         sbq[$];
   logic [127:0] gold [16];
   rd_vec_t      vt [12];
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Feedback taps 4,3,2,0 expressed as a parity over mask 8'h1D.
   function automatic void gen_gold(input logic [7:0] s);
      logic [7:0] v;
      v = s;
      for (int n = 0; n < 256; n++) begin
         gold[n / 16][127 - 8 * (n % 16) -: 8] = v;
         v = {^(v & 8'h1D), v[7:1]};
      end
   endfunction

   task automatic expect_key(input logic src, input logic [3:0] idx);
      exp_t e;
      e.key = gold[idx];
      e.src = src;
      e.idx = idx;
      sbq.push_back(e);
   endtask

   // Counts edges after the accepting edge until done; everything in between must be quiet.
   task automatic run_gen(input int req0_at, input int start_at, output int lat);
      int bad;
      bad = 0;
      lat = 0;
      while (lat < 400) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         start = (lat == start_at);
         if (lat == req0_at) req0 = 1'b1;
         #1;
         if (done) break;
         if (gnt0 || gnt1 || !busy || err) bad++;
      end
      chk("gen_quiet", 128'(bad), 128'(0));
      chk("gen_latency", 128'(lat), 128'(256));
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         chk("key_vld", 128'(key_vld), 128'(sbq.size() != 0));
         if (key_vld && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("key_out", key_out, e.key);
            chk("key_src", 128'(key_src), 128'(e.src));
            chk("key_idx", 128'(key_idx), 128'(e.idx));
         end
         chk("err_done_excl", 128'(err & done), 128'(0));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int bad;

      // Pointer starts with req0 last served (after the first read below).
      vt[0]  = '{1'b0, 1'b1, 4'd0,  4'd10, 1'b0, 1'b1};
      vt[1]  = '{1'b1, 1'b1, 4'd3,  4'd7,  1'b1, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 4'd3,  4'd7,  1'b0, 1'b1};
      vt[3]  = '{1'b1, 1'b0, 4'd15, 4'd0,  1'b1, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0};
      vt[5]  = '{1'b1, 1'b1, 4'd5,  4'd6,  1'b0, 1'b1};
      vt[6]  = '{1'b1, 1'b1, 4'd12, 4'd2,  1'b1, 1'b0};
      vt[7]  = '{1'b0, 1'b0, 4'd4,  4'd4,  1'b0, 1'b0};
      vt[8]  = '{1'b0, 1'b1, 4'd0,  4'd15, 1'b0, 1'b1};
      vt[9]  = '{1'b1, 1'b1, 4'd1,  4'd14, 1'b1, 1'b0};
      vt[10] = '{1'b1, 1'b1, 4'd1,  4'd14, 1'b0, 1'b1};
      vt[11] = '{1'b1, 1'b1, 4'd8,  4'd9,  1'b1, 1'b0};

      gen_gold(8'h1D);

      // Reset values, with requests pending in IDLE.
      req0 = 1'b1;
      req1 = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_key_out", key_out, 128'(0));
      chk("rst_key_src", 128'(key_src), 128'(0));
      chk("rst_key_idx", 128'(key_idx), 128'(0));
      chk("rst_gnt", 128'({gnt0, gnt1}), 128'(0));
      rst_an = 1'b1;
      #1;
      chk("idle_gnt", 128'({gnt0, gnt1}), 128'(0));
      req0 = 1'b0;
      req1 = 1'b0;

      // Zero effective seed in IDLE.
      @(negedge clk);
      start = 1'b1; use_seed = 1'b1; seed = 8'h00;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("zero_err", 128'(err), 128'(1));
      chk("zero_busy", 128'(busy), 128'(0));
      @(negedge clk);
      #1;
      chk("zero_err_pulse", 128'(err), 128'(0));
      chk("zero_busy2", 128'(busy), 128'(0));

      // Default-seed generation with req0 raised during GEN.
      use_seed = 1'b0;
      idx0 = 4'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("gen_busy", 128'(busy), 128'(1));
      run_gen(5, -1, lat);
      chk("gen_done", 128'(done), 128'(1));
      chk("gen_busy_low", 128'(busy), 128'(0));
      chk("first_gnt0", 128'(gnt0), 128'(1));
      chk("first_gnt1", 128'(gnt1), 128'(0));
      expect_key(1'b0, 4'd0);
      @(negedge clk);
      req0 = 1'b0;
      #1;
      chk("done_pulse", 128'(done), 128'(0));
      chk("key0_top48", 128'(key_out[127:80]), 128'(48'h1D0E070381C0));

      // Arbitration vectors.
      foreach (vt[i]) begin
         @(negedge clk);
         req0 = vt[i].r0; req1 = vt[i].r1;
         idx0 = vt[i].i0; idx1 = vt[i].i1;
         #1;
         chk($sformatf("vec%0d_gnt0", i), 128'(gnt0), 128'(vt[i].g0));
         chk($sformatf("vec%0d_gnt1", i), 128'(gnt1), 128'(vt[i].g1));
         if (vt[i].g0) expect_key(1'b0, vt[i].i0);
         else if (vt[i].g1) expect_key(1'b1, vt[i].i1);
      end
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;

      // Zero seed in READY keeps state and table.
      @(negedge clk);
      start = 1'b1; use_seed = 1'b1; seed = 8'h00;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("rdy_zero_err", 128'(err), 128'(1));
      chk("rdy_zero_busy", 128'(busy), 128'(0));
      @(negedge clk);
      req1 = 1'b1; idx1 = 4'd4;
      #1;
      chk("rdy_zero_gnt1", 128'(gnt1), 128'(1));
      expect_key(1'b1, 4'd4);
      @(negedge clk);
      req1 = 1'b0;

      // Start with req0 pending in READY; a start mid-GEN is ignored.
      @(negedge clk);
      req0 = 1'b1; idx0 = 4'd9;
      start = 1'b1; use_seed = 1'b1; seed = 8'hA5;
      #1;
      chk("start_wins_gnt0", 128'(gnt0), 128'(0));
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("restart_busy", 128'(busy), 128'(1));
      chk("restart_gnt0", 128'(gnt0), 128'(0));
      gen_gold(8'hA5);
      run_gen(-1, 50, lat);
      chk("regen_done", 128'(done), 128'(1));
      chk("regen_gnt0", 128'(gnt0), 128'(1));
      expect_key(1'b0, 4'd9);
      @(negedge clk);
      req0 = 1'b0;

      // Reset in the middle of GEN.
      @(negedge clk);
      use_seed = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      rst_an = 1'b0;
      #1;
      chk("midrst_busy", 128'(busy), 128'(0));
      @(negedge clk);
      rst_an = 1'b1;
      req1 = 1'b1; idx1 = 4'd2;
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         #1;
         if (gnt1 || gnt0 || done || busy) bad++;
      end
      chk("midrst_quiet", 128'(bad), 128'(0));
      @(negedge clk);
      start = 1'b1;
      #1;
      chk("midrst_start_gnt1", 128'(gnt1), 128'(0));
      @(negedge clk);
      start = 1'b0;
      gen_gold(8'h1D);
      run_gen(-1, -1, lat);
      chk("midrst_done", 128'(done), 128'(1));
      chk("midrst_gnt1", 128'(gnt1), 128'(1));
      expect_key(1'b1, 4'd2);
      @(negedge clk);
      req1 = 1'b0;

      repeat (3) @(negedge clk);
      chk("sb_drain", 128'(sbq.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
